ex_operand_stage: RTL and testbench

// - ID->EX pipeline register feeding the ALU in the 32-bit MIPS core: latches decoded op, resolves operands, drives ALU op_code/operand1/operand2/enable.
// - Valid/ready handshake with decode (upstream) and EX consumer (downstream); one entry of buffering; stall, flush, RAW forwarding.

---
 rtl/ex_operand_stage.sv | 174 +++++++++++++++++
 tb/tb_ex_operand_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register: latches the decoded op, resolves operands, drives the ALU.
// Define EX_FORWARD_EN for RAW forwarding/refresh; otherwise RAW hazards stall (hazard_stall).
// Ports: clk, rst (async, active-high), flush;
//   id_* = decode handshake and operands, exm_* / wb_* = forward buses;
//   ex_ready / ex_valid and ex_* = ALU side; illegal_op (sticky), hazard_stall.
module ex_operand_stage #(
    parameter int D_WIDTH  = 32,
    parameter int RA_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [2:0]          id_op_code,
    input  logic [RA_WIDTH-1:0] id_rs_addr,
    input  logic [RA_WIDTH-1:0] id_rt_addr,
    input  logic [D_WIDTH-1:0]  id_rs_data,
    input  logic [D_WIDTH-1:0]  id_rt_data,
    input  logic [D_WIDTH-1:0]  id_imm,
    input  logic                id_use_imm,
    input  logic [RA_WIDTH-1:0] id_rd_addr,
    input  logic                id_reg_write,
    input  logic                exm_reg_write,
    input  logic [RA_WIDTH-1:0] exm_rd_addr,
    input  logic [D_WIDTH-1:0]  exm_result,
    input  logic                wb_reg_write,
    input  logic [RA_WIDTH-1:0] wb_rd_addr,
    input  logic [D_WIDTH-1:0]  wb_result,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [2:0]          ex_op_code,
    output logic [D_WIDTH-1:0]  ex_operand1,
    output logic [D_WIDTH-1:0]  ex_operand2,
    output logic [RA_WIDTH-1:0] ex_rd_addr,
    output logic                ex_reg_write,
    output logic                illegal_op,
    output logic                hazard_stall
);

    logic                valid_q, valid_d;
    logic [2:0]          op_q, op_d;
    logic [D_WIDTH-1:0]  op1_q, op1_d;
    logic [D_WIDTH-1:0]  op2_q, op2_d;
    logic [RA_WIDTH-1:0] rd_q, rd_d;
    logic                rw_q, rw_d;
    logic                ill_q, ill_d;
    logic [RA_WIDTH-1:0] rs_q, rs_d;
    logic [RA_WIDTH-1:0] rt_q, rt_d;
    logic                uimm_q, uimm_d;

    logic                accept;
    logic [D_WIDTH-1:0]  cap_op1;
    logic [D_WIDTH-1:0]  cap_op2;

`ifdef EX_FORWARD_EN
    // EX/MEM beats MEM/WB; register 0 is never forwarded.
    function automatic logic [D_WIDTH-1:0] fwd(
        input logic [RA_WIDTH-1:0] r,
        input logic [D_WIDTH-1:0]  raw
    );
        logic [D_WIDTH-1:0] res;
        res = raw;
        if (r != '0) begin
            if (exm_reg_write && exm_rd_addr == r)
                res = exm_result;
            else if (wb_reg_write && wb_rd_addr == r)
                res = wb_result;
        end
        return res;
    endfunction

    assign hazard_stall = 1'b0;
    assign cap_op1 = fwd(id_rs_addr, id_rs_data);
    assign cap_op2 = id_use_imm ? id_imm : fwd(id_rt_addr, id_rt_data);
`else
    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_reg_write && (exm_rd_addr != '0) &&
                     ((exm_rd_addr == id_rs_addr) ||
                      (!id_use_imm && exm_rd_addr == id_rt_addr));
    assign wb_hit  = wb_reg_write && (wb_rd_addr != '0) &&
                     ((wb_rd_addr == id_rs_addr) ||
                      (!id_use_imm && wb_rd_addr == id_rt_addr));

    assign hazard_stall = id_valid && (exm_hit || wb_hit);
    assign cap_op1 = id_rs_data;
    assign cap_op2 = id_use_imm ? id_imm : id_rt_data;

    // Forward data and held source tags have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{exm_result, wb_result, rs_q, rt_q, uimm_q};
`endif

    assign id_ready = !flush && !hazard_stall && (!valid_q || ex_ready);
    assign accept   = id_valid && id_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        ill_d   = ill_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        uimm_d  = uimm_q;

`ifdef EX_FORWARD_EN
        // Refresh held operands so a downstream stall cannot leave stale data.
        if (valid_q) begin
            op1_d = fwd(rs_q, op1_q);
            if (!uimm_q)
                op2_d = fwd(rt_q, op2_q);
        end
`endif

        if (accept) begin
            valid_d = 1'b1;
            op_d    = id_op_code;
            op1_d   = cap_op1;
            op2_d   = cap_op2;
            rd_d    = id_rd_addr;
            rw_d    = id_reg_write;
            rs_d    = id_rs_addr;
            rt_d    = id_rt_addr;
            uimm_d  = id_use_imm;
            // Op codes 6 and 7 are undefined for the ALU.
            ill_d   = ill_q || (id_op_code[2] && id_op_code[1]);
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end

        if (flush)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            uimm_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ill_q   <= ill_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            uimm_q  <= uimm_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_op_code   = op_q;
    assign ex_operand1  = op1_q;
    assign ex_operand2  = op2_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q;
    assign illegal_op   = ill_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage.
// Scoreboard queue filled on accept, drained on ex_valid & ex_ready.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_op_code;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        exm_reg_write;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [2:0]  ex_op_code;
    logic [31:0] ex_operand1;
    logic [31:0] ex_operand2;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        illegal_op;
    logic        hazard_stall;

    ex_operand_stage #(.D_WIDTH(32), .RA_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_op_code(id_op_code),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
        .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
        .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_op_code(ex_op_code),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .illegal_op(illegal_op), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

`ifdef EX_FORWARD_EN
    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] raw);
        if (r == 5'd0) return raw;
        if (exm_reg_write && exm_rd_addr == r) return exm_result;
        if (wb_reg_write && wb_rd_addr == r) return wb_result;
        return raw;
    endfunction
`endif

    // Scoreboard: every consumed entry must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_valid && ex_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL sb_unexpected got op=%0d op1=%h required none",
                         ex_op_code, ex_operand1);
            end else begin
                e = q.pop_front();
                if ({ex_op_code, ex_operand1, ex_operand2, ex_rd_addr, ex_reg_write} !==
                    {e.op, e.op1, e.op2, e.rd, e.rw})
                    $display("FAIL sb_entry got %0d/%h/%h/%0d/%b required %0d/%h/%h/%0d/%b",
                             ex_op_code, ex_operand1, ex_operand2, ex_rd_addr, ex_reg_write,
                             e.op, e.op1, e.op2, e.rd, e.rw);
                else
                    n_pass++;
            end
        end
    end

    // Offer one instruction; returns one step after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic ui,
                        input logic [4:0] rd, input logic rw);
        exp_t e;
        bit   ok;
        ok = 0;
        id_op_code = op; id_rs_addr = rs; id_rt_addr = rt;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_use_imm = ui; id_rd_addr = rd; id_reg_write = rw;
        id_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL send_timeout id_ready=%b required 1", id_ready);
        end else begin
            n_pass++;
            e.op = op; e.rd = rd; e.rw = rw;
`ifdef EX_FORWARD_EN
            e.op1 = mfwd(rs, rsd);
            e.op2 = ui ? imm : mfwd(rt, rtd);
`else
            e.op1 = rsd;
            e.op2 = ui ? imm : rtd;
`endif
            q.push_back(e);
        end
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        id_op_code = '0; id_rs_addr = '0; id_rt_addr = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_use_imm = 1'b0; id_rd_addr = '0; id_reg_write = 1'b0;
        exm_reg_write = 1'b0; exm_rd_addr = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd_addr = '0; wb_result = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_op_code, ex_operand1, ex_operand2, ex_rd_addr,
             ex_reg_write, illegal_op} !== '0)
            $display("FAIL reset_state got v=%b op=%0d o1=%h o2=%h rd=%0d rw=%b ill=%b required all 0",
                     ex_valid, ex_op_code, ex_operand1, ex_operand2, ex_rd_addr,
                     ex_reg_write, illegal_op);
        else n_pass++;
        n_checks++;
        if (id_ready !== 1'b1)
            $display("FAIL reset_ready got %b required 1", id_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int c0;
        ex_ready = 1'b1;
        c0 = cyc;
        send(3'd0, 5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 1'b0, 5'd3, 1'b1);
        n_checks++;
        if (ex_valid !== 1'b1 || ex_operand1 !== 32'h100 || ex_op_code !== 3'd0)
            $display("FAIL b2b_first got v=%b op=%0d o1=%h required 1/0/100",
                     ex_valid, ex_op_code, ex_operand1);
        else n_pass++;
        send(3'd1, 5'd4, 5'd5, 32'h400, 32'h500, 32'hFFFF_FFFC, 1'b1, 5'd6, 1'b1);
        n_checks++;
        if (ex_valid !== 1'b1 || ex_operand2 !== 32'hFFFF_FFFC || ex_op_code !== 3'd1)
            $display("FAIL b2b_second got v=%b op=%0d o2=%h required 1/1/fffffffc",
                     ex_valid, ex_op_code, ex_operand2);
        else n_pass++;
        send(3'd0, 5'd7, 5'd8, 32'h7777, 32'h8888, 32'h0, 1'b0, 5'd9, 1'b0);
        n_checks++;
        if (cyc - c0 !== 3)
            $display("FAIL b2b_throughput got %0d cycles required 3", cyc - c0);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ex_valid !== 1'b0 || ex_operand1 !== 32'h7777)
            $display("FAIL drain got v=%b o1=%h required 0/7777", ex_valid, ex_operand1);
        else n_pass++;
    endtask

    task automatic test_hold;
        ex_ready = 1'b0;
        send(3'd2, 5'd8, 5'd9, 32'h1234, 32'h5678, 32'h0, 1'b0, 5'd10, 1'b1);
        id_valid = 1'b1;
        id_rs_data = 32'hBAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ex_valid !== 1'b1 || id_ready !== 1'b0 ||
                ex_operand1 !== 32'h1234 || ex_operand2 !== 32'h5678)
                $display("FAIL hold got v=%b rdy=%b o1=%h o2=%h required 1/0/1234/5678",
                         ex_valid, id_ready, ex_operand1, ex_operand2);
            else n_pass++;
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        send(3'd3, 5'd11, 5'd12, 32'h2, 32'h3, 32'hFFFF_FFF0, 1'b1, 5'd13, 1'b1);
        n_checks++;
        if (ex_valid !== 1'b1 || ex_op_code !== 3'd3 || ex_operand2 !== 32'hFFFF_FFF0)
            $display("FAIL replace got v=%b op=%0d o2=%h required 1/3/fffffff0",
                     ex_valid, ex_op_code, ex_operand2);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        ex_ready = 1'b0;
        send(3'd4, 5'd10, 5'd11, 32'hAAAA, 32'h5, 32'h0, 1'b0, 5'd12, 1'b1);
        flush = 1'b1;
        id_valid = 1'b1; id_op_code = 3'd5; id_rs_data = 32'hDEAD;
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b0)
            $display("FAIL flush_ready got %b required 0", id_ready);
        else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b0 || ex_operand1 !== 32'hAAAA || ex_op_code !== 3'd4)
            $display("FAIL flush_drop got v=%b o1=%h op=%0d required 0/aaaa/4",
                     ex_valid, ex_operand1, ex_op_code);
        else n_pass++;
        if (q.size() > 0) void'(q.pop_front());
        ex_ready = 1'b1;
    endtask

    task automatic test_illegal;
        ex_ready = 1'b1;
        n_checks++;
        if (illegal_op !== 1'b0)
            $display("FAIL illegal_clear got %b required 0", illegal_op);
        else n_pass++;
        send(3'd7, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 5'd3, 1'b1);
        n_checks++;
        if (illegal_op !== 1'b1 || ex_op_code !== 3'd7 || ex_valid !== 1'b1)
            $display("FAIL illegal_set got ill=%b op=%0d v=%b required 1/7/1",
                     illegal_op, ex_op_code, ex_valid);
        else n_pass++;
        send(3'd1, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 5'd3, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (illegal_op !== 1'b1)
            $display("FAIL illegal_sticky got %b required 1", illegal_op);
        else n_pass++;
    endtask

`ifdef EX_FORWARD_EN
    task automatic test_forward;
        ex_ready = 1'b1;
        exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_result = 32'h22;
        send(3'd0, 5'd5, 5'd1, 32'h99, 32'h98, 32'h0, 1'b0, 5'd2, 1'b1);
        n_checks++;
        if (ex_operand1 !== 32'h11 || hazard_stall !== 1'b0)
            $display("FAIL fwd_priority got o1=%h hz=%b required 11/0",
                     ex_operand1, hazard_stall);
        else n_pass++;
        exm_rd_addr = 5'd0; exm_result = 32'h77;
        send(3'd0, 5'd0, 5'd1, 32'h3333, 32'h1, 32'h0, 1'b0, 5'd2, 1'b1);
        n_checks++;
        if (ex_operand1 !== 32'h3333)
            $display("FAIL fwd_reg0 got %h required 3333", ex_operand1);
        else n_pass++;
        exm_reg_write = 1'b0; wb_rd_addr = 5'd6;
        send(3'd1, 5'd1, 5'd6, 32'h1, 32'h66, 32'h0, 1'b0, 5'd2, 1'b1);
        n_checks++;
        if (ex_operand2 !== 32'h22)
            $display("FAIL fwd_wb_rt got %h required 22", ex_operand2);
        else n_pass++;
        wb_reg_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_refresh;
        ex_ready = 1'b0;
        send(3'd0, 5'd7, 5'd7, 32'h1, 32'h2, 32'h55, 1'b1, 5'd8, 1'b1);
        wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'hABCD;
        @(posedge clk); #1;
        wb_reg_write = 1'b0;
        n_checks++;
        if (ex_operand1 !== 32'hABCD || ex_operand2 !== 32'h55 || ex_valid !== 1'b1)
            $display("FAIL refresh got o1=%h o2=%h v=%b required abcd/55/1",
                     ex_operand1, ex_operand2, ex_valid);
        else n_pass++;
        if (q.size() > 0) q[0].op1 = 32'hABCD;
        ex_ready = 1'b1;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_hazard;
        ex_ready = 1'b1;
        exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'hEEEE;
        id_valid = 1'b1; id_rs_addr = 5'd3; id_rt_addr = 5'd1;
        id_use_imm = 1'b0; id_rs_data = 32'h3030; id_op_code = 3'd0;
        @(negedge clk);
        n_checks++;
        if (hazard_stall !== 1'b1 || id_ready !== 1'b0)
            $display("FAIL hz_exm_rs got hz=%b rdy=%b required 1/0", hazard_stall, id_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ex_valid !== 1'b0)
            $display("FAIL hz_no_capture got v=%b required 0", ex_valid);
        else n_pass++;
        exm_reg_write = 1'b0;
        send(3'd0, 5'd3, 5'd1, 32'h3030, 32'h1, 32'h0, 1'b0, 5'd2, 1'b1);
        n_checks++;
        if (ex_operand1 !== 32'h3030)
            $display("FAIL hz_release got o1=%h required 3030", ex_operand1);
        else n_pass++;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'h4444;
        id_valid = 1'b1; id_rs_addr = 5'd1; id_rt_addr = 5'd4; id_use_imm = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hazard_stall !== 1'b1)
            $display("FAIL hz_wb_rt got %b required 1", hazard_stall);
        else n_pass++;
        id_use_imm = 1'b1;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0 || id_ready !== 1'b1)
            $display("FAIL hz_imm got hz=%b rdy=%b required 0/1", hazard_stall, id_ready);
        else n_pass++;
        wb_reg_write = 1'b0;
        exm_reg_write = 1'b1; exm_rd_addr = 5'd0; id_rs_addr = 5'd0;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0)
            $display("FAIL hz_reg0 got %b required 0", hazard_stall);
        else n_pass++;
        id_valid = 1'b0; exm_reg_write = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_hold;
        ex_ready = 1'b0;
        send(3'd1, 5'd2, 5'd3, 32'hCAFE, 32'hF00D, 32'h0, 1'b0, 5'd9, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ex_valid, ex_op_code, ex_operand1, ex_operand2, ex_rd_addr,
             ex_reg_write, illegal_op} !== '0)
            $display("FAIL rst_mid_hold got v=%b op=%0d o1=%h o2=%h rd=%0d rw=%b ill=%b required all 0",
                     ex_valid, ex_op_code, ex_operand1, ex_operand2, ex_rd_addr,
                     ex_reg_write, illegal_op);
        else n_pass++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (id_ready !== 1'b1)
            $display("FAIL rst_release_ready got %b required 1", id_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_flush();
        test_illegal();
`ifdef EX_FORWARD_EN
        test_forward();
        test_refresh();
`else
        test_hazard();
`endif
        test_reset_mid_hold();
        n_checks++;
        if (q.size() != 0)
            $display("FAIL sb_leftover got %0d entries required 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
